// File: rtl/flash_arbiter.sv
// flash_arbiter: shares one byte-wide flash between instruction fetch
// (32-bit little-endian word reads) and the data stage (byte load/store).
// Sequences cs/we/re/addr, waits READ_LAT cycles per read, returns a
// one-cycle ack per request. All outputs are registered.
// Build option: define FLASH_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise data has fixed priority over fetch.
module flash_arbiter #(
  parameter int READ_LAT = 2,
  parameter int AW       = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [7:0]    d_wdata,
  output logic [7:0]    d_rdata,
  output logic          d_ack,
  output logic          fl_cs,
  output logic          fl_we,
  output logic          fl_re,
  output logic [AW-1:0] fl_addr,
  output logic [7:0]    fl_in,
  input  logic [7:0]    fl_out,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Wait counter runs 0..READ_LAT-1; the last value is the sampling edge.
  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_LAT - 1);

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_fetch_q, is_fetch_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [23:0]     word_q, word_d;

  logic            fl_cs_q, fl_cs_d;
  logic            fl_we_q, fl_we_d;
  logic            fl_re_q, fl_re_d;
  logic [AW-1:0]   fl_addr_q, fl_addr_d;
  logic [7:0]      fl_in_q, fl_in_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [7:0]      d_rdata_q, d_rdata_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            busy_q, busy_d;

  logic            grant_data;
  logic [1:0]      idx_inc;

`ifdef FLASH_ARB_RR_EN
  // 0 = fetch was granted last, 1 = data was granted last
  localparam logic LG_FETCH = 1'b0;
  localparam logic LG_DATA  = 1'b1;
  logic            last_grant_q, last_grant_d;
`endif

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    is_fetch_d = is_fetch_q;
    we_d       = we_q;
    addr_d     = addr_q;
    word_d     = word_q;
    fl_cs_d    = fl_cs_q;
    fl_we_d    = fl_we_q;
    fl_re_d    = fl_re_q;
    fl_addr_d  = fl_addr_q;
    fl_in_d    = fl_in_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    idx_inc    = idx_q + 2'd1;

`ifdef FLASH_ARB_RR_EN
    last_grant_d = last_grant_q;
    // On a tie the port that did not win last time gets the flash.
    grant_data   = d_req && (!if_req || (last_grant_q == LG_FETCH));
`else
    // Data stage always wins a tie.
    grant_data   = d_req;
`endif

    case (state_q)
      IDLE: begin
        if (d_req || if_req) begin
          state_d    = ADDR;
          is_fetch_d = !grant_data;
          we_d       = grant_data && d_we;
          addr_d     = grant_data ? d_addr : if_addr;
          idx_d      = 2'd0;
          fl_cs_d    = 1'b1;
          fl_addr_d  = grant_data ? d_addr : if_addr;
          if (grant_data && d_we) begin
            fl_we_d = 1'b1;
            fl_in_d = d_wdata;
          end else begin
            fl_re_d = 1'b1;
          end
`ifdef FLASH_ARB_RR_EN
          last_grant_d = grant_data ? LG_DATA : LG_FETCH;
`endif
        end
      end

      ADDR: begin
        if (we_q) begin
          // Store completes after its single write strobe cycle.
          state_d = DONE;
          fl_cs_d = 1'b0;
          fl_we_d = 1'b0;
          d_ack_d = 1'b1;
        end else begin
          // Reads keep cs/re/addr stable through the wait window.
          state_d = WAIT;
          cnt_d   = '0;
        end
      end

      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          if (!is_fetch_q) begin
            d_rdata_d = fl_out;
            state_d   = DONE;
            fl_cs_d   = 1'b0;
            fl_re_d   = 1'b0;
            d_ack_d   = 1'b1;
          end else if (idx_q == 2'd3) begin
            // Last byte: publish the whole word only now so a reset
            // mid-fetch never exposes a partial word.
            if_rdata_d = {fl_out, word_q};
            state_d    = DONE;
            fl_cs_d    = 1'b0;
            fl_re_d    = 1'b0;
            if_ack_d   = 1'b1;
          end else begin
            word_d[8*idx_q +: 8] = fl_out;
            idx_d                = idx_inc;
            fl_addr_d            = addr_q + AW'(idx_inc);
            state_d              = ADDR;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        fl_cs_d = 1'b0;
        fl_we_d = 1'b0;
        fl_re_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      is_fetch_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      word_q     <= '0;
      fl_cs_q    <= 1'b0;
      fl_we_q    <= 1'b0;
      fl_re_q    <= 1'b0;
      fl_addr_q  <= '0;
      fl_in_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      is_fetch_q <= is_fetch_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      fl_cs_q    <= fl_cs_d;
      fl_we_q    <= fl_we_d;
      fl_re_q    <= fl_re_d;
      fl_addr_q  <= fl_addr_d;
      fl_in_q    <= fl_in_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      busy_q     <= busy_d;
    end
  end

`ifdef FLASH_ARB_RR_EN
  // Last-grant register; resets to fetch so the first tie goes to data
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= LG_FETCH;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign fl_cs    = fl_cs_q;
  assign fl_we    = fl_we_q;
  assign fl_re    = fl_re_q;
  assign fl_addr  = fl_addr_q;
  assign fl_in    = fl_in_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Testbench for flash_arbiter: flash device model with enforced read
// latency, reference model of arbitration/latency/memory contents, and a
// scoreboard monitor that checks every ack, read address and write strobe.
module tb_flash_arbiter;
  localparam int RL    = 2;
  localparam int AW    = 24;
  localparam int LAT_F = 4 * (RL + 1) + 1;
  localparam int LAT_L = RL + 2;
  localparam int LAT_S = 2;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [7:0]    d_wdata;
  logic [7:0]    d_rdata;
  logic          d_ack;
  logic          fl_cs;
  logic          fl_we;
  logic          fl_re;
  logic [AW-1:0] fl_addr;
  logic [7:0]    fl_in;
  logic [7:0]    fl_out;
  logic          busy;

  flash_arbiter #(.READ_LAT(RL), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .fl_cs(fl_cs), .fl_we(fl_we), .fl_re(fl_re), .fl_addr(fl_addr),
    .fl_in(fl_in), .fl_out(fl_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit          is_f;
    bit          chk;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [23:0] a;
    logic [7:0]  d;
  } wr_t;

  exp_t        sb_q[$];
  logic [23:0] rda_q[$];
  wr_t         wr_q[$];

  logic [7:0] dev_mem [logic [23:0]];
  logic [7:0] ref_mem [logic [23:0]];
  bit         last_f = 1'b1;

  logic        m_prev_re = 1'b0;
  logic [23:0] m_prev_a  = '0;
  logic        f_prev_re = 1'b0;
  logic [23:0] f_prev_a  = '0;
  int          f_age     = 0;

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'hFF;
  endfunction

  function automatic logic [7:0] dev_rd(input logic [23:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return 8'hFF;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Flash device: data only valid once address/re held long enough
  initial begin
    fl_out = 8'h00;
    forever begin
      @(negedge clk);
      if (fl_we) dev_mem[fl_addr] = fl_in;
      if (fl_re && f_prev_re && fl_addr == f_prev_a) f_age++;
      else f_age = fl_re ? 1 : 0;
      f_prev_re = fl_re;
      f_prev_a  = fl_addr;
      if (fl_re && f_age >= RL + 1) fl_out = dev_rd(fl_addr);
      else fl_out = ~dev_rd(fl_addr);
    end
  end

  task automatic check_ack(input bit f, input logic [31:0] v);
    exp_t e;
    compared++;
    if (sb_q.size() == 0) begin
      mismatched++;
      $display("FAIL ack_unexpected: %s ack data=%h at edge %0d, required no ack",
               f ? "fetch" : "data", v, cyc + 1);
    end else begin
      e = sb_q.pop_front();
      if (e.is_f != f || (e.chk && e.data !== v) || e.cyc != cyc + 1) begin
        mismatched++;
        $display("FAIL ack: got port=%s data=%h edge=%0d, required port=%s data=%h edge=%0d",
                 f ? "fetch" : "data", v, cyc + 1, e.is_f ? "fetch" : "data",
                 e.data, e.cyc);
      end else begin
        $display("txn %s ack data=%h edge=%0d ok", f ? "fetch" : "data", v, cyc + 1);
      end
    end
  endtask

  // Scoreboard monitor
  initial forever begin
    logic [23:0] ea;
    wr_t         ew;
    @(negedge clk);
    if (rst) begin
      compared++;
      if (fl_we && fl_re) begin
        mismatched++;
        $display("FAIL we_re_excl: fl_we=%0b fl_re=%0b, required not both 1", fl_we, fl_re);
      end
      compared++;
      if (fl_cs !== (fl_we | fl_re)) begin
        mismatched++;
        $display("FAIL cs_gate: fl_cs=%0b, required %0b", fl_cs, fl_we | fl_re);
      end
      if (if_ack && d_ack) begin
        compared++;
        mismatched++;
        $display("FAIL ack_both: if_ack=1 d_ack=1, required at most one");
      end
      if (if_ack) check_ack(1'b1, if_rdata);
      if (d_ack) check_ack(1'b0, {24'h0, d_rdata});
      if (fl_re && (!m_prev_re || fl_addr != m_prev_a)) begin
        compared++;
        if (rda_q.size() == 0) begin
          mismatched++;
          $display("FAIL rd_addr: unexpected read at %h, required none", fl_addr);
        end else begin
          ea = rda_q.pop_front();
          if (fl_addr !== ea) begin
            mismatched++;
            $display("FAIL rd_addr: got %h, required %h", fl_addr, ea);
          end
        end
      end
      if (fl_we) begin
        compared++;
        if (wr_q.size() == 0) begin
          mismatched++;
          $display("FAIL wr_strobe: unexpected write %h@%h, required none", fl_in, fl_addr);
        end else begin
          ew = wr_q.pop_front();
          if (fl_addr !== ew.a || fl_in !== ew.d) begin
            mismatched++;
            $display("FAIL wr_strobe: got %h@%h, required %h@%h", fl_in, fl_addr, ew.d, ew.a);
          end
        end
      end
    end
    m_prev_re = fl_re;
    m_prev_a  = fl_addr;
  end

  task automatic check_zero(input string name);
    compared++;
    if ({fl_cs, fl_we, fl_re, fl_addr, fl_in, if_rdata, d_rdata, if_ack, d_ack, busy} !== '0) begin
      mismatched++;
      $display("FAIL %s: cs=%0b we=%0b re=%0b addr=%h in=%h if_rdata=%h d_rdata=%h acks=%0b%0b busy=%0b, required all 0",
               name, fl_cs, fl_we, fl_re, fl_addr, fl_in, if_rdata, d_rdata, if_ack, d_ack, busy);
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!busy) return;
    end
    compared++;
    mismatched++;
    $display("FAIL idle_timeout: busy=1 after 100 cycles, required 0");
  endtask

  // Issue one or two simultaneous requests and record expectations
  task automatic run(input bit do_f, input logic [23:0] fa, input bit do_d,
                     input bit dwe, input logic [23:0] da, input logic [7:0] dw);
    bit   order[$];
    int   t;
    int   lat;
    bit   d_first;
    logic [31:0] w;
    exp_t e;
    wait_idle();
    t = cyc + 1;
`ifdef FLASH_ARB_RR_EN
    d_first = last_f;
`else
    d_first = 1'b1;
`endif
    if (do_f && do_d) begin
      if (d_first) begin order.push_back(1'b0); order.push_back(1'b1); end
      else begin order.push_back(1'b1); order.push_back(1'b0); end
    end else if (do_f) order.push_back(1'b1);
    else if (do_d) order.push_back(1'b0);
    foreach (order[k]) begin
      if (order[k]) begin
        for (int i = 0; i < 4; i++) begin
          w[8*i +: 8] = ref_rd(fa + 24'(i));
          rda_q.push_back(fa + 24'(i));
        end
        lat = LAT_F;
        e = '{1'b1, 1'b1, w, t + lat};
        last_f = 1'b1;
      end else if (dwe) begin
        ref_mem[da] = dw;
        wr_q.push_back('{da, dw});
        lat = LAT_S;
        e = '{1'b0, 1'b0, 32'h0, t + lat};
        last_f = 1'b0;
      end else begin
        rda_q.push_back(da);
        lat = LAT_L;
        e = '{1'b0, 1'b1, {24'h0, ref_rd(da)}, t + lat};
        last_f = 1'b0;
      end
      sb_q.push_back(e);
      t = t + lat + 1;
    end
    if_addr = fa;  if_req = do_f;
    d_addr = da;   d_we = dwe;  d_wdata = dw;  d_req = do_d;
    for (int n = 0; n < 200 && (if_req || d_req); n++) begin
      @(negedge clk);
      if (if_req && if_ack) if_req = 1'b0;
      if (d_req && d_ack) d_req = 1'b0;
    end
    if (if_req || d_req) begin
      compared++;
      mismatched++;
      $display("FAIL ack_timeout: if_req=%0b d_req=%0b still pending, required acked", if_req, d_req);
      if_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  initial begin
    bit found;
    logic [7:0] b;
    logic [23:0] a;
    int kind;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      b = 8'($urandom);
      dev_mem[24'(i)] = b; ref_mem[24'(i)] = b;
      b = 8'($urandom);
      dev_mem[24'hFFFFC0 + 24'(i)] = b; ref_mem[24'hFFFFC0 + 24'(i)] = b;
    end
    dev_mem[24'h0] = 8'h83; ref_mem[24'h0] = 8'h83;
    dev_mem[24'h1] = 8'h02; ref_mem[24'h1] = 8'h02;
    dev_mem[24'h2] = 8'h00; ref_mem[24'h2] = 8'h00;
    dev_mem[24'h3] = 8'h02; ref_mem[24'h3] = 8'h02;
    dev_mem[24'h20] = 8'h10; ref_mem[24'h20] = 8'h10;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b1;

    run(1'b1, 24'h000000, 1'b0, 1'b0, 24'h0, 8'h0);      // fetch word 0x02000283
    run(1'b0, 24'h0, 1'b1, 1'b0, 24'h000020, 8'h0);      // load 0x10
    run(1'b0, 24'h0, 1'b1, 1'b1, 24'h000022, 8'h14);     // store
    run(1'b0, 24'h0, 1'b1, 1'b0, 24'h000022, 8'h0);      // load back 0x14
    run(1'b1, 24'h000000, 1'b1, 1'b0, 24'h000020, 8'h0); // tie
    run(1'b1, 24'hFFFFFE, 1'b0, 1'b0, 24'h0, 8'h0);      // address wrap

    // Reset during the wait of fetch byte 2
    wait_idle();
    for (int i = 0; i < 4; i++) rda_q.push_back(24'(i));
    if_addr = 24'h0;
    if_req = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (fl_re && fl_addr == 24'h2) found = 1'b1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL abort_reach: fetch byte 2 address never presented, required 000002");
    end
    @(negedge clk);
    rst = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    check_zero("abort_reset");
    rst = 1'b1;
    rda_q.delete();
    last_f = 1'b1;
    run(1'b1, 24'h000000, 1'b0, 1'b0, 24'h0, 8'h0);      // fresh fetch after abort
    run(1'b1, 24'h000000, 1'b1, 1'b1, 24'h000021, 8'h5A); // tie after reset

    for (int r = 0; r < 40; r++) begin
      kind = int'($urandom_range(0, 4));
      a = ($urandom_range(0, 3) == 0) ? 24'hFFFFFC + 24'($urandom_range(0, 3))
                                      : 24'($urandom_range(0, 63));
      case (kind)
        0: run(1'b1, a, 1'b0, 1'b0, 24'h0, 8'h0);
        1: run(1'b0, 24'h0, 1'b1, 1'b0, a, 8'h0);
        2: run(1'b0, 24'h0, 1'b1, 1'b1, a, 8'($urandom));
        3: run(1'b1, a, 1'b1, 1'b0, 24'($urandom_range(0, 63)), 8'h0);
        default: run(1'b1, a, 1'b1, 1'b1, 24'($urandom_range(0, 63)), 8'($urandom));
      endcase
    end

    wait_idle();
    repeat (3) @(negedge clk);
    compared++;
    if (sb_q.size() != 0 || rda_q.size() != 0 || wr_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: sb=%0d rd=%0d wr=%0d pending, required 0",
               sb_q.size(), rda_q.size(), wr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
